// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [ID_W-1:0] req_id_t;
endpackage

// File: rtl/rr_arb8_ctrl_if.sv
// Requester-side bundle: request/release inputs and the grant outputs.
interface rr_arb8_ctrl_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  req_id_t          grant_id;
  logic             grant_valid;
  logic             timeout;

  modport master (output req, done, input grant, grant_id, grant_valid, timeout);
  modport slave  (input req, done, output grant, grant_id, grant_valid, timeout);
endinterface

// File: rtl/rr_arb8_ctrl_dec.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module dec3to8_en (
  input  logic [2:0] a,
  input  logic       en,
  output logic [7:0] y
);
  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign y[gi] = en && (a == 3'(gi));
  end
endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 requesters with release handshake, max-hold
// timeout and back-to-back re-grant on release.
module rr_arb8_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic           clk,
  input  logic           reset,
  rr_arb8_ctrl_if.slave  bus
);
  // With the timeout disabled the counter simply saturates at all-ones.
  localparam logic [CNT_W-1:0] CNT_MAX = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  arb_state_t        state_reg;
  req_id_t           ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  req_id_t           grant_id_reg;
  logic              grant_valid_reg;
  logic [N_REQ-1:0]  grant_reg;
  logic              timeout_reg;

  req_id_t           base;
  req_id_t           idx;
  req_id_t           win_id;
  logic              win_found;
  logic [N_REQ-1:0]  win_onehot;
  logic              timeout_hit;
  logic              release_now;

  // While granted, the search already starts at grant_id+1, so a release
  // re-arbitrates with the pointer value it is about to write.
  always_comb begin
    base      = (state_reg == GRANT) ? req_id_t'(grant_id_reg + req_id_t'(1)) : ptr_reg;
    idx       = '0;
    win_id    = '0;
    win_found = 1'b0;
    // Descending scan: the smallest offset from base is assigned last and wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = req_id_t'(base + req_id_t'(i));
      if (bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign timeout_hit = (MAX_HOLD != 0) && (cnt_reg == CNT_MAX) && !bus.done;
  assign release_now = bus.done || !bus.req[grant_id_reg] || timeout_hit;

  dec3to8_en u_dec (
    .a  (win_id),
    .en (win_found),
    .y  (win_onehot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      cnt_reg         <= '0;
      grant_id_reg    <= '0;
      grant_valid_reg <= 1'b0;
      grant_reg       <= '0;
      timeout_reg     <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            grant_id_reg    <= win_id;
            grant_reg       <= win_onehot;
            grant_valid_reg <= 1'b1;
            cnt_reg         <= CNT_W'(1);
            state_reg       <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_reg     <= req_id_t'(grant_id_reg + req_id_t'(1));
            timeout_reg <= timeout_hit;
            if (win_found) begin
              grant_id_reg <= win_id;
              grant_reg    <= win_onehot;
              cnt_reg      <= CNT_W'(1);
            end else begin
              grant_valid_reg <= 1'b0;
              grant_reg       <= '0;
              cnt_reg         <= '0;
              state_reg       <= IDLE;
            end
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_id    = grant_id_reg;
  assign bus.grant_valid = grant_valid_reg;
  assign bus.timeout     = timeout_reg;
endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed vector bench for rr_arb8_ctrl (built with MAX_HOLD=4).
module tb_rr_arb8_ctrl;
  logic clk = 1'b0;
  logic reset;

  rr_arb8_ctrl_if bus ();

  rr_arb8_ctrl #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       valid;
    logic [2:0] id;
    logic       chk_id;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic rst, input logic [7:0] req, input logic done,
                     input logic [7:0] grant, input logic valid, input logic [2:0] id,
                     input logic chk_id, input logic to);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done; v.grant = grant;
    v.valid = valid; v.id = id; v.chk_id = chk_id; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] req, input logic done);
    reset    = rst;
    bus.req  = req;
    bus.done = done;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_id;
    logic [7:0] exp_gnt;
    logic [7:0] one;

    reset = 1'b1; bus.req = 8'h00; bus.done = 1'b0;
    one = 8'h01;

    //   rst req    done grant  vld id chk to
    add(1, 8'hFF, 0, 8'h00, 0, 0, 1, 0);
    add(1, 8'hFF, 0, 8'h00, 0, 0, 1, 0);
    add(1, 8'hFF, 0, 8'h00, 0, 0, 1, 0);
    add(0, 8'hFF, 0, 8'h01, 1, 0, 1, 0);
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    add(0, 8'h20, 0, 8'h20, 1, 5, 1, 0);
    add(0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    add(0, 8'h81, 0, 8'h80, 1, 7, 1, 0);
    add(0, 8'h81, 1, 8'h01, 1, 0, 1, 0);
    add(0, 8'h81, 1, 8'h80, 1, 7, 1, 0);
    add(0, 8'h81, 1, 8'h01, 1, 0, 1, 0);
    add(0, 8'h02, 0, 8'h02, 1, 1, 1, 0);
    add(0, 8'h02, 0, 8'h02, 1, 1, 1, 0);
    add(0, 8'h02, 0, 8'h02, 1, 1, 1, 0);
    add(0, 8'h02, 0, 8'h02, 1, 1, 1, 0);
    add(0, 8'h02, 0, 8'h02, 1, 1, 1, 1);
    add(0, 8'h02, 0, 8'h02, 1, 1, 1, 0);
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h08, 0, 8'h08, 1, 3, 1, 0);
    add(0, 8'h18, 0, 8'h08, 1, 3, 1, 0);
    add(0, 8'h10, 0, 8'h10, 1, 4, 1, 0);
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h18, 0, 8'h08, 1, 3, 1, 0);
    add(0, 8'h18, 0, 8'h08, 1, 3, 1, 0);
    add(0, 8'h18, 0, 8'h08, 1, 3, 1, 0);
    add(0, 8'h18, 0, 8'h08, 1, 3, 1, 0);
    add(0, 8'h18, 1, 8'h10, 1, 4, 1, 0);
    add(0, 8'h40, 0, 8'h40, 1, 6, 1, 0);
    add(1, 8'h48, 0, 8'h00, 0, 0, 1, 0);
    add(0, 8'h48, 0, 8'h08, 1, 3, 1, 0);
    add(0, 8'h48, 1, 8'h40, 1, 6, 1, 0);
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    add(0, 8'h01, 1, 8'h01, 1, 0, 1, 0);
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      $display("vec %0d rst=%0b req=%02h done=%0b -> grant=%02h valid=%0b id=%0d timeout=%0b",
               i, vecs[i].rst, vecs[i].req, vecs[i].done,
               bus.grant, bus.grant_valid, bus.grant_id, bus.timeout);
      chk($sformatf("vec%0d grant", i), 32'(bus.grant), 32'(vecs[i].grant));
      chk($sformatf("vec%0d valid", i), 32'(bus.grant_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d timeout", i), 32'(bus.timeout), 32'(vecs[i].to));
      if (vecs[i].chk_id)
        chk($sformatf("vec%0d grant_id", i), 32'(bus.grant_id), 32'(vecs[i].id));
    end

    // All requesters pending, done every cycle: strict rotation with no bubble.
    step(0, 8'hFF, 0);
    exp_id = 3'd1;
    chk("rot start id", 32'(bus.grant_id), 32'(exp_id));
    for (int k = 1; k <= 9; k++) begin
      step(0, 8'hFF, 1);
      exp_id  = exp_id + 3'd1;
      exp_gnt = one << exp_id;
      $display("rot %0d grant=%02h id=%0d valid=%0b", k, bus.grant, bus.grant_id, bus.grant_valid);
      chk($sformatf("rot%0d id", k), 32'(bus.grant_id), 32'(exp_id));
      chk($sformatf("rot%0d grant", k), 32'(bus.grant), 32'(exp_gnt));
      chk($sformatf("rot%0d onehot", k), 32'($onehot(bus.grant)), 32'(1));
    end

    // Hold without release: timeout after 4 granted cycles, then next in turn.
    for (int k = 1; k <= 5; k++) begin
      step(0, 8'hFF, 0);
      if (k == 4) exp_id = exp_id + 3'd1;
      $display("hold %0d grant=%02h id=%0d timeout=%0b", k, bus.grant, bus.grant_id, bus.timeout);
      chk($sformatf("hold%0d id", k), 32'(bus.grant_id), 32'(exp_id));
      chk($sformatf("hold%0d timeout", k), 32'(bus.timeout), 32'(k == 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
